// File: rtl/classificador_medida_n_pkg.sv
// Shared class codes and FSM state type for the averaging level classifier.
package classificador_pkg;

  localparam logic [2:0] CLASSE_NENHUMA = 3'b000;
  localparam logic [2:0] CLASSE_BAIXO   = 3'b001;
  localparam logic [2:0] CLASSE_ALTO    = 3'b010;
  localparam logic [2:0] CLASSE_CRITICO = 3'b011;
  localparam logic [2:0] CLASSE_NORMAL  = 3'b100;

  typedef enum logic [2:0] {
    OCIOSO,
    COLETA,
    DIVIDE,
    CLASSIFICA,
    FIM
  } estado_t;

endpackage

// File: rtl/classificador_medida_n_if.sv
// Sample handshake, threshold and result bundle of the averaging level classifier.
interface classificador_medida_n_if #(
  parameter int LARGURA = 12
);
  logic               iniciar;
  logic               abortar;
  logic [LARGURA-1:0] amostra;
  logic               amostra_valida;
  logic [LARGURA-1:0] nv_baixo;
  logic [LARGURA-1:0] nv_alto;
  logic [LARGURA-1:0] nv_crit;
  logic               pronto;
  logic               ocupado;
  logic [LARGURA-1:0] media;
  logic [LARGURA-1:0] maior_medida;
  logic [LARGURA-1:0] menor_medida;
  logic [2:0]         medida_classificacao;
  logic               descartar_medida;
  logic               fim_classificacao;

  modport master (
    output iniciar, abortar, amostra, amostra_valida, nv_baixo, nv_alto, nv_crit,
    input  pronto, ocupado, media, maior_medida, menor_medida,
           medida_classificacao, descartar_medida, fim_classificacao
  );

  modport slave (
    input  iniciar, abortar, amostra, amostra_valida, nv_baixo, nv_alto, nv_crit,
    output pronto, ocupado, media, maior_medida, menor_medida,
           medida_classificacao, descartar_medida, fim_classificacao
  );
endinterface

// File: rtl/classificador_medida_n_divisor.sv
// Restoring divider by a constant: one quotient bit per cycle, ACC_W cycles after iniciar.
module divisor_seq #(
  parameter int ACC_W   = 14,
  parameter int DIVISOR = 3
) (
  input  logic             clock,
  input  logic             zera,
  input  logic             iniciar,
  input  logic [ACC_W-1:0] dividendo,
  output logic [ACC_W-1:0] quociente,
  output logic             pronto
);
  localparam int             CNT_W = $clog2(ACC_W + 1);
  localparam logic [ACC_W:0] DIV_V = (ACC_W + 1)'(DIVISOR);

  logic [ACC_W-1:0] resto;
  logic [CNT_W-1:0] passos;
  logic             ativo;
  logic [ACC_W:0]   tentativa;
  logic [ACC_W:0]   diferenca;
  logic             cabe;
  logic             unused_dif;

  // The remainder stays below DIVISOR, so its top bit after subtraction is always zero
  always_comb begin
    tentativa = {resto, quociente[ACC_W-1]};
    diferenca = tentativa - DIV_V;
    cabe      = (tentativa >= DIV_V);
  end

  assign unused_dif = diferenca[ACC_W];

  always_ff @(posedge clock) begin
    if (zera) begin
      resto     <= '0;
      quociente <= '0;
      passos    <= '0;
      ativo     <= 1'b0;
    end else if (iniciar) begin
      resto     <= '0;
      quociente <= dividendo;
      passos    <= CNT_W'(ACC_W);
      ativo     <= 1'b1;
    end else if (passos != '0) begin
      resto     <= cabe ? diferenca[ACC_W-1:0] : tentativa[ACC_W-1:0];
      quociente <= {quociente[ACC_W-2:0], cabe};
      passos    <= passos - CNT_W'(1);
    end
  end

  assign pronto = ativo && (passos == '0);

endmodule

// File: rtl/classificador_medida_n.sv
// Collects N_MEDIDAS samples, averages them and classifies the mean against latched thresholds.
module classificador_medida_n
  import classificador_pkg::*;
#(
  parameter int LARGURA   = 12,
  parameter int N_MEDIDAS = 3,
  parameter int MAX_DIFF  = 4
) (
  input logic                     clock,
  input logic                     zera,
  classificador_medida_n_if.slave bus
);
  localparam int          ACC_W      = LARGURA + $clog2(N_MEDIDAS);
  localparam int          CNT_W      = $clog2(N_MEDIDAS);
  localparam logic [31:0] MAX_DIFF_V = 32'(MAX_DIFF);

  estado_t estado;
  estado_t proximo;

  logic [ACC_W-1:0]   soma;
  logic [ACC_W-1:0]   soma_nova;
  logic [ACC_W-1:0]   quociente_full;
  logic [CNT_W-1:0]   contador;
  logic [LARGURA-1:0] maior_acc;
  logic [LARGURA-1:0] menor_acc;
  logic [LARGURA-1:0] baixo_r;
  logic [LARGURA-1:0] alto_r;
  logic [LARGURA-1:0] crit_r;
  logic [LARGURA-1:0] media_nova;
  logic [LARGURA-1:0] spread;
  logic [LARGURA-1:0] media_r;
  logic [LARGURA-1:0] maior_r;
  logic [LARGURA-1:0] menor_r;
  logic [2:0]         classe_r;
  logic [2:0]         classe_nova;
  logic               descartar_r;
  logic               aceita;
  logic               ultima;
  logic               div_pronto;
  logic               unused_quo;

  // The divider is loaded on the accepting edge itself, with the sum including the last sample
  always_comb begin
    aceita     = (estado == COLETA) && bus.amostra_valida && !bus.abortar;
    ultima     = aceita && (contador == CNT_W'(N_MEDIDAS - 1));
    soma_nova  = soma + ACC_W'(bus.amostra);
    media_nova = quociente_full[LARGURA-1:0];
    spread     = maior_acc - menor_acc;
    if (media_nova < baixo_r)
      classe_nova = CLASSE_BAIXO;
    else if (media_nova < alto_r)
      classe_nova = CLASSE_NORMAL;
    else if (media_nova <= crit_r)
      classe_nova = CLASSE_ALTO;
    else
      classe_nova = CLASSE_CRITICO;
  end

  assign unused_quo = ^quociente_full[ACC_W-1:LARGURA];

  always_ff @(posedge clock) begin
    if (zera)
      estado <= OCIOSO;
    else
      estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:     if (bus.iniciar) proximo = COLETA;
      COLETA:     if (bus.abortar) proximo = OCIOSO;
                  else if (ultima) proximo = DIVIDE;
      DIVIDE:     if (bus.abortar) proximo = OCIOSO;
                  else if (div_pronto) proximo = CLASSIFICA;
      CLASSIFICA: proximo = bus.abortar ? OCIOSO : FIM;
      FIM:        proximo = OCIOSO;
      default:    proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (zera) begin
      soma        <= '0;
      contador    <= '0;
      maior_acc   <= '0;
      menor_acc   <= '0;
      baixo_r     <= '0;
      alto_r      <= '0;
      crit_r      <= '0;
      media_r     <= '0;
      maior_r     <= '0;
      menor_r     <= '0;
      classe_r    <= CLASSE_NENHUMA;
      descartar_r <= 1'b0;
    end else begin
      if ((estado == OCIOSO) && bus.iniciar) begin
        baixo_r   <= bus.nv_baixo;
        alto_r    <= bus.nv_alto;
        crit_r    <= bus.nv_crit;
        soma      <= '0;
        contador  <= '0;
        maior_acc <= '0;
        menor_acc <= '1;
      end
      if (aceita) begin
        soma     <= soma_nova;
        contador <= contador + CNT_W'(1);
        if (bus.amostra > maior_acc) maior_acc <= bus.amostra;
        if (bus.amostra < menor_acc) menor_acc <= bus.amostra;
      end
      if ((estado == CLASSIFICA) && !bus.abortar) begin
        media_r     <= media_nova;
        maior_r     <= maior_acc;
        menor_r     <= menor_acc;
        classe_r    <= classe_nova;
        descartar_r <= (32'(spread) > MAX_DIFF_V);
      end
    end
  end

  divisor_seq #(
    .ACC_W   (ACC_W),
    .DIVISOR (N_MEDIDAS)
  ) u_divisor (
    .clock     (clock),
    .zera      (zera),
    .iniciar   (ultima),
    .dividendo (soma_nova),
    .quociente (quociente_full),
    .pronto    (div_pronto)
  );

  assign bus.pronto               = (estado == COLETA);
  assign bus.ocupado              = (estado != OCIOSO);
  assign bus.fim_classificacao    = (estado == FIM);
  assign bus.media                = media_r;
  assign bus.maior_medida         = maior_r;
  assign bus.menor_medida         = menor_r;
  assign bus.medida_classificacao = classe_r;
  assign bus.descartar_medida     = descartar_r;

endmodule

// File: tb/tb_classificador_medida_n.sv
// Scoreboard bench: two classifier instances (default and N=8/LARGURA=10) against an arithmetic model.
module tb_classificador_medida_n;

  typedef struct {
    int     media;
    int     maior;
    int     menor;
    int     cls;
    int     desc;
    longint fim_cyc;
  } exp_t;

  localparam int ACC_A = 14;
  localparam int ACC_B = 13;

  logic   clock = 1'b0;
  logic   zera  = 1'b1;
  longint cyc   = 0;
  int     checks   = 0;
  int     failures = 0;
  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   last_a;
  exp_t   ea;
  exp_t   eb;

  classificador_medida_n_if #(.LARGURA(12)) bus_a ();
  classificador_medida_n_if #(.LARGURA(10)) bus_b ();

  classificador_medida_n #(.LARGURA(12), .N_MEDIDAS(3), .MAX_DIFF(4)) dut_a (
    .clock (clock),
    .zera  (zera),
    .bus   (bus_a.slave)
  );

  classificador_medida_n #(.LARGURA(10), .N_MEDIDAS(8), .MAX_DIFF(4)) dut_b (
    .clock (clock),
    .zera  (zera),
    .bus   (bus_b.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic exp_t model(input int s[$], input int lo, input int hi, input int crit,
                                 input int maxd);
    exp_t e;
    int   sum = 0;
    int   mx  = s[0];
    int   mn  = s[0];
    foreach (s[i]) begin
      sum += s[i];
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    e.media = sum / s.size();
    e.maior = mx;
    e.menor = mn;
    e.desc  = ((mx - mn) > maxd) ? 1 : 0;
    if (e.media < lo)        e.cls = 1;
    else if (e.media < hi)   e.cls = 4;
    else if (e.media <= crit) e.cls = 2;
    else                     e.cls = 3;
    e.fim_cyc = 0;
    return e;
  endfunction

  // Monitors: each completion pulse pops one expected result
  always @(negedge clock) begin
    if (bus_a.fim_classificacao) begin
      if (q_a.size() == 0) fail_timeout("a_unexpected_fim");
      else begin
        ea = q_a.pop_front();
        check_output("a_media", longint'(bus_a.media), ea.media);
        check_output("a_maior", longint'(bus_a.maior_medida), ea.maior);
        check_output("a_menor", longint'(bus_a.menor_medida), ea.menor);
        check_output("a_classe", longint'(bus_a.medida_classificacao), ea.cls);
        check_output("a_descartar", longint'(bus_a.descartar_medida), ea.desc);
        check_output("a_latency", cyc, ea.fim_cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (bus_b.fim_classificacao) begin
      if (q_b.size() == 0) fail_timeout("b_unexpected_fim");
      else begin
        eb = q_b.pop_front();
        check_output("b_media", longint'(bus_b.media), eb.media);
        check_output("b_maior", longint'(bus_b.maior_medida), eb.maior);
        check_output("b_menor", longint'(bus_b.menor_medida), eb.menor);
        check_output("b_classe", longint'(bus_b.medida_classificacao), eb.cls);
        check_output("b_descartar", longint'(bus_b.descartar_medida), eb.desc);
        check_output("b_latency", cyc, eb.fim_cyc);
      end
    end
  end

  task automatic wait_idle_a();
    int t = 0;
    @(negedge clock);
    while (bus_a.ocupado && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) fail_timeout("a_idle");
  endtask

  task automatic wait_idle_b();
    int t = 0;
    @(negedge clock);
    while (bus_b.ocupado && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) fail_timeout("b_idle");
  endtask

  // Thresholds are scrambled right after the start edge; the model keeps the latched ones
  task automatic start_a(input int lo, input int hi, input int crit, input bit valid_start);
    wait_idle_a();
    bus_a.nv_baixo = 12'(lo);
    bus_a.nv_alto  = 12'(hi);
    bus_a.nv_crit  = 12'(crit);
    bus_a.iniciar  = 1'b1;
    if (valid_start) begin
      bus_a.amostra        = 12'd3999;
      bus_a.amostra_valida = 1'b1;
    end
    @(posedge clock);
    #1;
    bus_a.iniciar        = 1'b0;
    bus_a.amostra_valida = 1'b0;
    bus_a.nv_baixo       = 12'($urandom_range(0, 4095));
    bus_a.nv_alto        = 12'($urandom_range(0, 4095));
    bus_a.nv_crit        = 12'($urandom_range(0, 4095));
  endtask

  task automatic send_a(input int v, input int gap, output longint acc);
    int t = 0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    bus_a.amostra        = 12'(v);
    bus_a.amostra_valida = 1'b1;
    @(negedge clock);
    while (!bus_a.pronto && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) fail_timeout("a_pronto");
    @(posedge clock);
    #1;
    acc = cyc;
    bus_a.amostra_valida = 1'b0;
  endtask

  task automatic apply_batch_a(input int s0, input int s1, input int s2,
                               input int g0, input int g1, input int g2,
                               input int lo, input int hi, input int crit,
                               input bit valid_start, input bit ini_div);
    int     s[$];
    exp_t   e;
    longint acc;
    int     t = 0;
    s = {s0, s1, s2};
    start_a(lo, hi, crit, valid_start);
    send_a(s0, g0, acc);
    send_a(s1, g1, acc);
    send_a(s2, g2, acc);
    e = model(s, lo, hi, crit, 4);
    e.fim_cyc = acc + ACC_A + 2;
    q_a.push_back(e);
    last_a = e;
    if (ini_div) begin
      repeat (3) @(posedge clock);
      #1;
      bus_a.iniciar = 1'b1;
      @(posedge clock);
      #1;
      bus_a.iniciar = 1'b0;
      @(negedge clock);
      while (!bus_a.fim_classificacao && t < 100) begin
        @(negedge clock);
        t++;
      end
      if (t >= 100) fail_timeout("a_fim");
      @(negedge clock);
      check_output("a_iniciar_in_divide_ignored", longint'(bus_a.ocupado), 0);
    end
  endtask

  task automatic apply_batch_b(input int s[$], input int lo, input int hi, input int crit);
    exp_t   e;
    longint acc = 0;
    int     t;
    wait_idle_b();
    bus_b.nv_baixo = 10'(lo);
    bus_b.nv_alto  = 10'(hi);
    bus_b.nv_crit  = 10'(crit);
    bus_b.iniciar  = 1'b1;
    @(posedge clock);
    #1;
    bus_b.iniciar  = 1'b0;
    bus_b.nv_baixo = 10'($urandom_range(0, 1023));
    bus_b.nv_alto  = 10'($urandom_range(0, 1023));
    bus_b.nv_crit  = 10'($urandom_range(0, 1023));
    foreach (s[i]) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clock);
        #1;
      end
      bus_b.amostra        = 10'(s[i]);
      bus_b.amostra_valida = 1'b1;
      t = 0;
      @(negedge clock);
      while (!bus_b.pronto && t < 300) begin
        @(negedge clock);
        t++;
      end
      if (t >= 300) fail_timeout("b_pronto");
      @(posedge clock);
      #1;
      acc = cyc;
      bus_b.amostra_valida = 1'b0;
    end
    e = model(s, lo, hi, crit, 4);
    e.fim_cyc = acc + ACC_B + 2;
    q_b.push_back(e);
  endtask

  task automatic check_zero_a(input string tag);
    check_output({tag, "_media"}, longint'(bus_a.media), 0);
    check_output({tag, "_maior"}, longint'(bus_a.maior_medida), 0);
    check_output({tag, "_menor"}, longint'(bus_a.menor_medida), 0);
    check_output({tag, "_classe"}, longint'(bus_a.medida_classificacao), 0);
    check_output({tag, "_descartar"}, longint'(bus_a.descartar_medida), 0);
    check_output({tag, "_fim"}, longint'(bus_a.fim_classificacao), 0);
    check_output({tag, "_ocupado"}, longint'(bus_a.ocupado), 0);
  endtask

  initial begin
    int     sb[$];
    int     base;
    int     lo;
    int     hi;
    int     crit;
    int     t;
    longint acc;
    int     v[3];

    bus_a.iniciar = 1'b0; bus_a.abortar = 1'b0; bus_a.amostra = '0; bus_a.amostra_valida = 1'b0;
    bus_a.nv_baixo = '0; bus_a.nv_alto = '0; bus_a.nv_crit = '0;
    bus_b.iniciar = 1'b0; bus_b.abortar = 1'b0; bus_b.amostra = '0; bus_b.amostra_valida = 1'b0;
    bus_b.nv_baixo = '0; bus_b.nv_alto = '0; bus_b.nv_crit = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_a("a_reset");
    check_output("a_reset_pronto", longint'(bus_a.pronto), 0);
    check_output("b_reset_classe", longint'(bus_b.medida_classificacao), 0);
    @(posedge clock);
    #1;
    zera = 1'b0;

    apply_batch_a(100, 102, 101, 0, 0, 0, 50, 200, 300, 1'b0, 1'b0);
    apply_batch_a(100, 110, 105, 0, 3, 1, 50, 200, 300, 1'b1, 1'b0);
    apply_batch_a(200, 200, 200, 0, 0, 0, 50, 200, 300, 1'b0, 1'b0);
    apply_batch_a(300, 300, 300, 1, 0, 0, 50, 200, 300, 1'b0, 1'b0);
    apply_batch_a(301, 301, 301, 0, 2, 0, 50, 200, 300, 1'b0, 1'b0);
    apply_batch_a(49, 49, 49, 0, 0, 0, 50, 200, 300, 1'b0, 1'b0);
    apply_batch_a(1, 1, 2, 0, 0, 0, 50, 200, 300, 1'b0, 1'b0);
    apply_batch_a(4095, 4095, 4095, 0, 0, 0, 50, 200, 3000, 1'b0, 1'b0);
    apply_batch_a(700, 703, 699, 0, 0, 0, 500, 800, 900, 1'b0, 1'b1);

    sb = {0, 1, 2, 3, 4, 5, 6, 7};
    apply_batch_b(sb, 1, 5, 6);

    for (int i = 0; i < 15; i++) begin
      base = $urandom_range(0, 4095);
      for (int k = 0; k < 3; k++) begin
        v[k] = base + $urandom_range(0, 7);
        if (v[k] > 4095) v[k] = 4095;
      end
      lo   = $urandom_range(0, 2000);
      hi   = lo + $urandom_range(0, 1500);
      crit = hi + $urandom_range(0, 1500) - 100;
      if (crit < 0) crit = 0;
      apply_batch_a(v[0], v[1], v[2], $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), lo, hi, crit, 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      base = $urandom_range(0, 1015);
      sb.delete();
      for (int k = 0; k < 8; k++) sb.push_back(base + $urandom_range(0, 8) % 1024);
      foreach (sb[k]) if (sb[k] > 1023) sb[k] = 1023;
      lo = $urandom_range(0, 500);
      apply_batch_b(sb, lo, lo + $urandom_range(0, 400), lo + $urandom_range(0, 500));
    end

    // Abort mid-collection: previous results stay, no completion pulse
    start_a(10, 20, 30, 1'b0);
    send_a(500, 0, acc);
    bus_a.abortar = 1'b1;
    @(posedge clock);
    #1;
    bus_a.abortar = 1'b0;
    @(negedge clock);
    check_output("a_abort_ocupado", longint'(bus_a.ocupado), 0);
    check_output("a_abort_media_kept", longint'(bus_a.media), last_a.media);
    check_output("a_abort_classe_kept", longint'(bus_a.medida_classificacao), last_a.cls);
    check_output("a_abort_maior_kept", longint'(bus_a.maior_medida), last_a.maior);
    repeat (30) @(posedge clock);

    // Reset in the middle of division: everything clears, no completion pulse
    start_a(50, 200, 300, 1'b0);
    send_a(1000, 0, acc);
    send_a(1001, 0, acc);
    send_a(1002, 0, acc);
    repeat (5) @(posedge clock);
    #1;
    zera = 1'b1;
    @(posedge clock);
    #1;
    zera = 1'b0;
    @(negedge clock);
    check_zero_a("a_zera_divide");
    repeat (30) @(posedge clock);

    apply_batch_a(1, 1, 2, 0, 0, 0, 50, 200, 300, 1'b0, 1'b0);

    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 500) begin
      @(posedge clock);
      t++;
    end
    repeat (3) @(posedge clock);
    check_output("a_queue_drained", q_a.size(), 0);
    check_output("b_queue_drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/classificador_medida_n.md
Name: classificador_medida_n

Overview:
Parametrised successor of the three-sample level classifier. It collects N_MEDIDAS samples of width LARGURA through a valid handshake, computes the floor mean, max, min and spread, and flags the batch for discard when the spread exceeds MAX_DIFF. It classifies the mean against thresholds latched at start and signals completion with a one-cycle pulse. It sits between the sensor sampling logic and the level-alarm/actuation FSM.

Parameters:
LARGURA, 12, sample and threshold width in bits (>=4)
N_MEDIDAS, 3, samples per batch (2..64)
MAX_DIFF, 4, maximum allowed (maior - menor); larger spread sets descartar_medida

Ports:
clock  in  1  system clock, all logic on rising edge
zera  in  1  synchronous active-high reset
iniciar  in  1  start request; sampled only in OCIOSO
abortar  in  1  synchronous abort; returns to OCIOSO, no fim pulse
amostra  in  LARGURA  sample data
amostra_valida  in  1  sample is accepted on any edge where amostra_valida && pronto
nv_baixo  in  LARGURA  low threshold, latched at iniciar
nv_alto  in  LARGURA  high threshold, latched at iniciar
nv_crit  in  LARGURA  critical threshold, latched at iniciar
pronto  out  1  high in COLETA only
ocupado  out  1  high in every state except OCIOSO
media  out  LARGURA  floor(sum/N_MEDIDAS)
maior_medida  out  LARGURA  batch maximum
menor_medida  out  LARGURA  batch minimum
medida_classificacao  out  3  class code
descartar_medida  out  1  spread > MAX_DIFF
fim_classificacao  out  1  one-cycle pulse; results valid from this cycle on

Behaviour:
- Reset: zera synchronously forces OCIOSO and clears all outputs, the accumulator, the counter and the latched thresholds to 0. It has priority over abortar, iniciar and amostra_valida in every state.
- Derived constant ACC_W = LARGURA + $clog2(N_MEDIDAS). The accumulator is ACC_W bits wide and never overflows.
- FSM states: OCIOSO -> COLETA -> DIVIDE -> CLASSIFICA -> FIM -> OCIOSO.
- OCIOSO: when iniciar=1, latch the three thresholds, clear sum and count, and preset maior to 0 and menor to all-ones. Next state is COLETA. Previous results stay on the outputs.
- COLETA: each accepted sample adds to the sum, updates maior/menor and increments the count. A valid sample in the iniciar cycle is not accepted. Gaps in amostra_valida are allowed, with no timeout. On the edge that accepts the N_MEDIDAS-th sample, go to DIVIDE and start the divider.
- DIVIDE: restoring division of the sum by N_MEDIDAS, one quotient bit per cycle, exactly ACC_W cycles. The quotient always fits in LARGURA bits and is truncated to that width.
- CLASSIFICA (1 cycle): register media, maior_medida and menor_medida.
  - descartar_medida = (maior - menor) > MAX_DIFF. Unsigned subtraction cannot underflow because maior >= menor.
  - Class codes, evaluated in this priority order:
    - media < nv_baixo -> 3'b001 (baixo)
    - media < nv_alto -> 3'b100 (normal)
    - media <= nv_crit -> 3'b010 (alto)
    - else -> 3'b011 (critico)
  - Code 3'b000 appears only after reset.
  - Classification is produced even when descartar_medida=1.
- FIM (1 cycle): fim_classificacao=1, then go to OCIOSO. Outputs hold until the next CLASSIFICA.
- Latency: fim_classificacao is high in the cycle starting ACC_W+2 rising edges after the edge that accepted the last sample. For the defaults (ACC_W=14) that is 16 edges.
- abortar in COLETA, DIVIDE or CLASSIFICA: next state OCIOSO. Result outputs keep their previous values and no fim pulse is produced. abortar in OCIOSO or FIM has no effect. If abortar and iniciar are both high in OCIOSO, iniciar wins.
- iniciar outside OCIOSO is ignored. It is level-sampled, so holding it high restarts a new batch immediately after FIM.
- Misordered thresholds (nv_baixo > nv_alto, etc.) are not checked; the priority order above alone defines the result.

Decomposition:
- Package classificador_pkg holds:
  - class code localparams CLASSE_NENHUMA=000, CLASSE_BAIXO=001, CLASSE_ALTO=010, CLASSE_CRITICO=011, CLASSE_NORMAL=100
  - the FSM state enum
- Sub-module divisor_seq: parameters ACC_W and DIVISOR; ports clock, zera, iniciar, dividendo, quociente, pronto; fixed ACC_W-cycle latency. It is reused by other averaging blocks.

Test Plan:
- Defaults, thresholds 50/200/300, samples 100,102,101 -> media=101, maior=102, menor=100, descartar=0, class=100, fim exactly 16 edges after the third sample.
- Samples 100,110,105 with gaps of 0, 3 and 1 idle cycles between valids -> media=105, descartar=1 (spread 10>4), class=100.
- Boundaries with thresholds 50/200/300: samples 200,200,200 -> class=010; 300,300,300 -> class=010; 301,301,301 -> class=011; 49,49,49 -> class=001. Samples 1,1,2 -> media=1 (floor).
- Samples 4095,4095,4095 with crit=3000 -> media=4095, class=011, no overflow.
- N_MEDIDAS=8, LARGURA=10: samples 0..7 -> media=3, maior=7, menor=0, descartar=1; fim 15 edges after the last sample.
- Sequencing: change thresholds during COLETA -> result uses the latched values. Assert zera mid-DIVIDE -> all outputs 0 next cycle, no fim. Assert abortar mid-COLETA -> OCIOSO, prior results retained; iniciar during DIVIDE ignored.
